fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory and decode.
- Owns the fetch PC, which drives the IM read address, and captures the combinational {PC, Instr} pair each cycle into a small FIFO.
- Presents entries to decode over a valid/ready handshake.
- A redirect from branch/jump resolution flushes the queue and restarts fetch at the target.

Parameters:
- INIT_ADDR, 32'h00003000, fetch PC after reset.
- DEPTH, 4, queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- fetch_pc  output  32  address to IM; registered
- fetch_instr  input  32  IM word for fetch_pc, combinational same cycle
- redirect_valid  input  1  flush queue, restart at redirect_pc
- redirect_pc  input  32  new fetch target; bits[1:0] ignored
- out_valid  output  1  head entry valid
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry
- out_pc4  output  32  out_pc + 4, modulo 2^32
- count  output  CNT_W  current occupancy, for debug/perf

Behaviour:
- Reset is synchronous and active-high. Reset clock edge sets:
  - fetch_pc = INIT_ADDR
  - rd_ptr = wr_ptr = count = 0
- After that edge: out_valid = 0, out_pc = out_instr = 0, out_pc4 = 4. Storage contents are don't-care.
- Reset overrides every other input, including redirect. Reset mid-stream discards all entries.
- Derived signals:
  - pop = out_valid & out_ready
  - push = ~redirect_valid & (count < DEPTH | pop)
  - Pushing when full is legal only when a pop happens in the same cycle.
- Push: write {fetch_pc, fetch_instr} at wr_ptr; wr_ptr increments modulo DEPTH; fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- No push: fetch_pc holds, so the IM is re-read with the same address.
- Pop: rd_ptr increments modulo DEPTH.
- count next value:
  - count + push − pop, or
  - 0 on a redirect edge.
- Outputs:
  - out_valid = (count != 0)
  - out_pc / out_instr / out_pc4 are read combinationally from the head entry.
  - When empty, outputs hold the last head values; the consumer must qualify them with out_valid.
- Redirect, in a cycle with redirect_valid = 1:
  - At the edge: count = 0, pointers reset to 0, fetch_pc = {redirect_pc[31:2], 2'b00}, no push.
  - A pop in the same cycle is accepted: the consumer saw the entry, and the flush discards the rest.
- Latency:
  - Fetch edge to out_valid is 1 cycle.
  - After reset or redirect, the first entry appears 1 cycle after the first fetch edge.
- Throughput: with out_ready held at 1, one entry per cycle, with no bubbles and no duplicates.
- No internal state machine beyond the pointers and counter. Full is count == DEPTH; empty is count == 0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and redirect_valid == 0:
  - out_valid = 1 and outputs are driven directly from {fetch_pc, fetch_instr}, giving zero-cycle latency.
  - If out_ready = 1, the entry is consumed without being written; fetch_pc still advances and count stays 0.
  - If out_ready = 0, the entry is pushed normally.
- Not defined: outputs come only from storage; minimum latency is 1 cycle.

Decomposition:
- Package fetch_pkg:
  - INIT_ADDR and INSTR_W = 32
  - typedef fq_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - PC_STEP = 4
- Sub-module fq_storage:
  - DEPTH × fq_entry_t array
  - synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata)
- Pointer, counter and redirect logic stay in fetch_queue.

Test Plan:
- Reset, then out_ready = 1 held → after reset: fetch_pc = 0x3000 and out_valid = 0; one cycle later out_pc = 0x3000 with the matching instr; then 0x3004, 0x3008, … one per cycle, with out_pc4 = out_pc + 4.
- out_ready = 0 for 10 cycles → count saturates at 4, fetch_pc holds 0x3010, out_pc holds 0x3000. On release: 0x3000, 0x3004, 0x3008, 0x300C, 0x3010 in consecutive cycles.
- With 3 entries queued, pulse redirect_valid with redirect_pc = 0x3041 → next cycle count = 0, out_valid = 0, fetch_pc = 0x3040; the cycle after, out_pc = 0x3040.
- Full queue, out_ready = 1 and redirect_valid = 1 in the same cycle → redirect wins: count = 0, no push, fetch_pc = redirect target.
- Assert reset with 2 entries queued → next cycle count = 0, out_valid = 0, fetch_pc = 0x3000.
- Redirect to 0xFFFFFFFC with out_ready = 1 → out_pc sequence 0xFFFFFFFC, 0x00000000, with out_pc4 = 0x00000000 for the first entry. With the bypass macro defined, the first entry appears in the cycle after the redirect edge, with no extra latency.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Used by fq_storage and fetch_queue.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] INIT_ADDR = 32'h0000_3000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // Fetch targets are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the prefetch queue.
// It has one synchronous write port and one combinational read port.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fq_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fq_entry_t     o_rdata
);

  fq_entry_t r_mem [DEPTH];

  // NOTE: the array is deliberately not reset; the occupancy counter alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC and buffers {pc, instr} pairs for decode.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when the queue is empty.
module fetch_queue #(
  parameter logic [31:0] INIT_ADDR = fetch_pkg::INIT_ADDR,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc4,
  output logic [CNT_W-1:0] count
);

  import fetch_pkg::*;

  localparam int               AW   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fq_entry_t        r_hold;

  logic      w_empty;
  logic      w_bypass;
  logic      w_valid;
  logic      w_pop;
  logic      w_push;
  logic      w_store;
  logic      w_unload;
  fq_entry_t w_fetch;
  fq_entry_t w_head;
  fq_entry_t w_out;

  assign w_fetch = '{pc: r_fetch_pc, instr: fetch_instr};
  assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & ~redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid  = ~w_empty | w_bypass;
  assign w_pop    = w_valid & out_ready;
  assign w_push   = ~redirect_valid & ((r_count < FULL) | w_pop);
  // A bypassed entry that decode takes this cycle never touches storage.
  assign w_store  = w_push & ~(w_bypass & w_pop);
  assign w_unload = w_pop & ~w_bypass;

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_fetch),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // When nothing is presentable the outputs keep the last entry decode consumed.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives w_out, so no latch is inferred.
    w_out = r_hold;
    if (w_bypass) begin
      w_out = w_fetch;
    end else if (!w_empty) begin
      w_out = w_head;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= INIT_ADDR;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_hold     <= '0;
    end else begin
      if (w_pop) begin
        r_hold <= w_out;
      end
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_store) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_unload) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_unload);
      end
    end
  end

  assign fetch_pc  = r_fetch_pc;
  assign count     = r_count;
  assign out_valid = w_valid;
  assign out_pc    = w_out.pc;
  assign out_instr = w_out.instr;
  assign out_pc4   = w_out.pc + PC_STEP;

  a_count_bound : assert property (@(posedge clk) disable iff (reset) r_count <= FULL);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
// Honors FETCH_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_instr;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc4;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {p[15:0], p[31:16]} ^ 32'hC3A5_1E69;
  endfunction

  assign fetch_instr = instr_of(fetch_pc);

  fetch_queue #(
    .INIT_ADDR (32'h0000_3000),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4),
    .count          (count)
  );

  // Reference model: a queue of fetched entries, the fetch PC and the last consumed entry.
  fq_entry_t   mq[$];
  logic [31:0] mpc   = 32'h0000_3000;
  fq_entry_t   mhold = '0;

  function automatic void model_out(input bit rv, output bit ev, output bit eb, output fq_entry_t ee);
    eb = 1'b0;
    if (mq.size() != 0) begin
      ev = 1'b1;
      ee = mq[0];
    end else if (BYP && !rv) begin
      ev = 1'b1;
      eb = 1'b1;
      ee = '{pc: mpc, instr: instr_of(mpc)};
    end else begin
      ev = 1'b0;
      ee = mhold;
    end
  endfunction

  // Advance one clock with the inputs currently driven; called from and returning to a falling edge.
  task automatic tick();
    bit          m_rst, m_rv, m_rdy, ev, eb, m_pop;
    logic [31:0] m_rpc;
    fq_entry_t   ee;
    m_rst = reset;
    m_rv  = redirect_valid;
    m_rdy = out_ready;
    m_rpc = redirect_pc;
    model_out(m_rv, ev, eb, ee);
    @(posedge clk);
    if (m_rst) begin
      mq.delete();
      mpc   = 32'h0000_3000;
      mhold = '0;
    end else begin
      m_pop = ev && m_rdy;
      if (m_pop) mhold = ee;
      if (m_rv) begin
        mq.delete();
        mpc = {m_rpc[31:2], 2'b00};
      end else begin
        if (m_pop && !eb) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          if (!(m_pop && eb)) mq.push_back('{pc: mpc, instr: instr_of(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (fetch_pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_fetch_pc got %h want %h", fetch_pc, 32'h0000_3000); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (out_valid !== BYP) begin n_err++; $display("FAIL reset_valid got %b want %b", out_valid, BYP); end
    n_vec++; if (out_pc !== (BYP ? 32'h0000_3000 : 32'h0)) begin n_err++; $display("FAIL reset_out_pc got %h", out_pc); end
    n_vec++; if (out_instr !== (BYP ? instr_of(32'h0000_3000) : 32'h0)) begin n_err++; $display("FAIL reset_out_instr got %h", out_instr); end
    n_vec++; if (out_pc4 !== (BYP ? 32'h0000_3004 : 32'h4)) begin n_err++; $display("FAIL reset_out_pc4 got %h", out_pc4); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    out_ready = 1'b1;
    if (!BYP) tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      e = 32'h0000_3000 + 32'(4 * i);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
      n_vec++; if (out_pc !== e) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, e); end
      n_vec++; if (out_instr !== instr_of(e)) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, instr_of(e)); end
      n_vec++; if (out_pc4 !== e + 32'd4) begin n_err++; $display("FAIL stream_pc4[%0d] got %h want %h", i, out_pc4, e + 32'd4); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    #1;
    n_vec++; if (count !== CNT_W'(4)) begin n_err++; $display("FAIL stall_count got %0d want 4", count); end
    n_vec++; if (fetch_pc !== 32'h0000_3010) begin n_err++; $display("FAIL stall_fetch_pc got %h want 00003010", fetch_pc); end
    n_vec++; if (out_pc !== 32'h0000_3000) begin n_err++; $display("FAIL stall_out_pc got %h want 00003000", out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = 32'h0000_3000 + 32'(4 * i);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== e) begin n_err++; $display("FAIL release_pc[%0d] got %b/%h want 1/%h", i, out_valid, out_pc, e); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    #1;
    n_vec++; if (count !== CNT_W'(3)) begin n_err++; $display("FAIL redir_pre_count got %0d want 3", count); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3041;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL redir_count got %0d want 0", count); end
    n_vec++; if (out_valid !== BYP) begin n_err++; $display("FAIL redir_valid got %b want %b", out_valid, BYP); end
    n_vec++; if (fetch_pc !== 32'h0000_3040) begin n_err++; $display("FAIL redir_fetch_pc got %h want 00003040", fetch_pc); end
    tick();
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_3040) begin n_err++; $display("FAIL redir_first got %b/%h want 1/00003040", out_valid, out_pc); end
    n_vec++; if (out_instr !== instr_of(32'h0000_3040)) begin n_err++; $display("FAIL redir_instr got %h want %h", out_instr, instr_of(32'h0000_3040)); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    repeat (6) tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5002;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL redir_full_count got %0d want 0", count); end
    n_vec++; if (fetch_pc !== 32'h0000_5000) begin n_err++; $display("FAIL redir_full_fetch_pc got %h want 00005000", fetch_pc); end
    n_vec++; if (out_valid !== BYP) begin n_err++; $display("FAIL redir_full_valid got %b want %b", out_valid, BYP); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL midreset_count got %0d want 0", count); end
    n_vec++; if (out_valid !== BYP) begin n_err++; $display("FAIL midreset_valid got %b want %b", out_valid, BYP); end
    n_vec++; if (fetch_pc !== 32'h0000_3000) begin n_err++; $display("FAIL midreset_fetch_pc got %h want 00003000", fetch_pc); end
  endtask

  task automatic test_wrap();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    if (!BYP) tick();
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first got %b/%h want 1/fffffffc", out_valid, out_pc); end
    n_vec++; if (out_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want 00000000", out_pc4); end
    tick();
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL wrap_second got %b/%h want 1/00000000", out_valid, out_pc); end
    n_vec++; if (out_pc4 !== 32'h4) begin n_err++; $display("FAIL wrap_second_pc4 got %h want 00000004", out_pc4); end
  endtask

  task automatic test_random();
    bit        ev, eb;
    fq_entry_t ee;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      out_ready      = ($urandom_range(0, 9) < 7);
      #1;
      model_out(redirect_valid, ev, eb, ee);
      n_vec++; if (out_valid !== ev) begin n_err++; $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, ev); end
      n_vec++; if (count !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rand_count[%0d] got %0d want %0d", i, count, mq.size()); end
      n_vec++; if (fetch_pc !== mpc) begin n_err++; $display("FAIL rand_fetch_pc[%0d] got %h want %h", i, fetch_pc, mpc); end
      n_vec++; if (out_pc !== ee.pc || out_instr !== ee.instr) begin n_err++; $display("FAIL rand_head[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, ee.pc, ee.instr); end
      n_vec++; if (out_pc4 !== ee.pc + 32'd4) begin n_err++; $display("FAIL rand_pc4[%0d] got %h want %h", i, out_pc4, ee.pc + 32'd4); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
